// File: rtl/twiddle_cmult_stage_if.sv
// Stream and twiddle-ROM bundle for twiddle_cmult_stage.
// The "slave" modport is the multiplier's view; "master" drives samples and ROM data.
interface twiddle_cmult_stage_if #(
    parameter int SIZE         = 8,
    parameter int bit_width    = 16,
    parameter int bit_width_tw = 14
);
    logic                           in_valid;
    logic signed [bit_width-1:0]    in_re;
    logic signed [bit_width-1:0]    in_im;
    logic                           tw_en;
    logic        [SIZE-2:0]         tw_addr;
    logic signed [bit_width_tw-1:0] cos_data;
    logic signed [bit_width_tw-1:0] sin_data;
    logic                           out_valid;
    logic signed [bit_width-1:0]    out_re;
    logic signed [bit_width-1:0]    out_im;
    logic                           out_last;

    modport slave (
        input  in_valid, in_re, in_im, cos_data, sin_data,
        output tw_en, tw_addr, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, cos_data, sin_data,
        input  tw_en, tw_addr, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/twiddle_cmult_stage.sv
// Streaming FFT-stage twiddle multiplier: drives the twiddle ROM and multiplies each sample.
// Define TWIDDLE_CMULT_SAT_EN to saturate results; otherwise they wrap to bit_width bits.
module twiddle_cmult_stage #(
    parameter int N            = 256,
    parameter int SIZE         = 8,
    parameter int STAGE        = 1,
    parameter int bit_width    = 16,
    parameter int bit_width_tw = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    twiddle_cmult_stage_if.slave  bus
);
    localparam int PW    = bit_width + bit_width_tw;
    localparam int SW    = PW + 1;
    localparam int SHIFT = bit_width_tw - 2;
    localparam int RW    = SW - SHIFT;

    localparam logic        [SIZE-1:0] TW_MASK  = SIZE'((N >> STAGE) - 1);
    localparam logic        [SIZE-1:0] LAST_CNT = SIZE'(N - 1);
    localparam logic signed [SW-1:0]   RND      = SW'(2 ** (bit_width_tw - 3));
    localparam logic signed [RW-1:0]   MAX_V    = RW'(2 ** (bit_width - 1) - 1);
    localparam logic signed [RW-1:0]   MIN_V    = -MAX_V - RW'(1);

    // Round half-up, then drop the Q-format fraction bits.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] t;
        t = x + RND;
        return RW'(t >>> SHIFT);
    endfunction

    function automatic logic signed [bit_width-1:0] reduce(input logic signed [RW-1:0] x);
`ifdef TWIDDLE_CMULT_SAT_EN
        if (x > MAX_V)
            return bit_width'(MAX_V);
        else if (x < MIN_V)
            return bit_width'(MIN_V);
        else
            return bit_width'(x);
`else
        return bit_width'(x);
`endif
    endfunction

    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] addr_full;

    logic                        vld_p0, last_p0;
    logic signed [bit_width-1:0] re_p0, im_p0;
    logic                        vld_p1, last_p1;
    logic signed [PW-1:0]        rr_p1, ii_p1, ri_p1, ir_p1;

    logic signed [SW-1:0]        re_sum, im_sum;
    logic signed [bit_width-1:0] re_res, im_res;

    assign bus.tw_en   = bus.in_valid;
    assign addr_full   = (cnt & TW_MASK) << (STAGE - 1);
    assign bus.tw_addr = addr_full[SIZE-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (bus.in_valid)
            cnt <= cnt + SIZE'(1);
    end

    // S1: sample registered so it lines up with the ROM's registered cos/sin.
    // S2: four partial products.
    always_ff @(posedge clk) begin
        re_p0 <= bus.in_re;
        im_p0 <= bus.in_im;
        rr_p1 <= PW'(re_p0) * PW'(bus.cos_data);
        ii_p1 <= PW'(im_p0) * PW'(bus.sin_data);
        ri_p1 <= PW'(re_p0) * PW'(bus.sin_data);
        ir_p1 <= PW'(im_p0) * PW'(bus.cos_data);
    end

    // S3: combine, round, reduce to output width.
    assign re_sum = SW'(rr_p1) - SW'(ii_p1);
    assign im_sum = SW'(ri_p1) + SW'(ir_p1);
    assign re_res = reduce(round_shift(re_sum));
    assign im_res = reduce(round_shift(im_sum));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            last_p0       <= 1'b0;
            vld_p1        <= 1'b0;
            last_p1       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
        end else begin
            vld_p0        <= bus.in_valid;
            last_p0       <= bus.in_valid && (cnt == LAST_CNT);
            vld_p1        <= vld_p0;
            last_p1       <= last_p0;
            bus.out_valid <= vld_p1;
            bus.out_last  <= last_p1;
            if (vld_p1) begin
                bus.out_re <= re_res;
                bus.out_im <= im_res;
            end
        end
    end
endmodule
